can_rx_deframer: RTL

Serial-to-parallel receive stage for the CAN-style frame stream produced by the transmit serializer. It samples one bit per clock from the line, tracks frame position with a state machine, validates the fixed fields, and presents ID, DLC and up to 8 data bytes with a one-cycle valid strobe. It sits directly downstream of the TX serializer's `bit_out` in loopback, or behind a line receiver.

---
 rtl/can_pkg.sv | 29 ++
 rtl/can_rx_deframer_if.sv | 29 ++
 rtl/can_rx_deframer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN receive definitions: field widths, counter sizing and the RX
// frame-position state enum used by can_rx_deframer and later RX stages.
package can_pkg;

  localparam int ID_W      = 11;
  localparam int DLC_W     = 4;
  localparam int MAX_BYTES = 8;
  localparam int BYTE_W    = 8;
  localparam int SOF_W     = 1;
  localparam int RSV_W     = 3;
  localparam int END_W     = 1;
  localparam int CNT_W     = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_ID,
    RX_RSV,
    RX_DLC,
    RX_DATA,
    RX_END,
    RX_ERR
  } rx_state_t;

  // Line length of a frame carrying dlc data bytes.
  function automatic int unsigned frame_bits(input logic [DLC_W-1:0] dlc);
    return SOF_W + ID_W + RSV_W + DLC_W + END_W + BYTE_W * int'(dlc);
  endfunction

endpackage

// File: rtl/can_rx_deframer_if.sv
// Parallel side of the CAN RX deframer: received frame fields, status strobes,
// consumer acknowledge and a debug view of the frame-position state.
interface can_rx_deframer_if;
  import can_pkg::*;

  // Handshake: rx_valid marks rx_id/rx_dlc/rx_data as a complete good frame.
  // Without CANRX_HOLD_EN it is a one-cycle strobe and rx_ack is ignored; with
  // it, rx_valid stays high until a clock edge samples rx_ack=1.
  logic [ID_W-1:0]                  rx_id;
  logic [DLC_W-1:0]                 rx_dlc;
  logic [MAX_BYTES-1:0][BYTE_W-1:0] rx_data;
  logic                             rx_valid;
  logic                             rx_err;
  logic                             rx_busy;
  logic                             rx_overrun;
  logic                             rx_ack;
  rx_state_t                        dbg_state;

  modport master (
    output rx_id, rx_dlc, rx_data, rx_valid, rx_err, rx_busy, rx_overrun, dbg_state,
    input  rx_ack
  );

  modport slave (
    input  rx_id, rx_dlc, rx_data, rx_valid, rx_err, rx_busy, rx_overrun, dbg_state,
    output rx_ack
  );

endinterface

// File: rtl/can_rx_deframer.sv
// Serial-to-parallel CAN-style frame receiver, one line bit per clock.
// Optional CANRX_HOLD_EN: rx_valid held until rx_ack, rx_overrun on a dropped frame.
module can_rx_deframer
  import can_pkg::*;
#(
  parameter int unsigned IDLE_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  can_rx_deframer_if.master rx
);

  localparam logic [3:0]       IDLE_TH = 4'(IDLE_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rx_state_t                        state_q;
  logic [3:0]                       idle_cnt_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [ID_W-1:0]                  sh_id_q, id_q;
  logic [DLC_W-1:0]                 sh_dlc_q, dlc_q;
  logic [MAX_BYTES-1:0][BYTE_W-1:0] sh_data_q, data_q;
  logic                             valid_q, err_q, busy_q;
  logic [DLC_W-1:0]                 dlc_d;
  logic                             frame_ok;
  logic                             load;

  assign dlc_d    = {sh_dlc_q[DLC_W-2:0], bit_in};
  assign frame_ok = (state_q == RX_END) && bit_in;

`ifdef CANRX_HOLD_EN
  logic ovr_q;
  // A finished frame is dropped only if the previous one is still unacknowledged.
  assign load          = frame_ok && !(valid_q && !rx.rx_ack);
  assign rx.rx_overrun = ovr_q;
`else
  logic unused_ack;
  assign unused_ack    = rx.rx_ack;
  assign load          = frame_ok;
  assign rx.rx_overrun = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      idle_cnt_q <= '0;
      cnt_q      <= '0;
      sh_id_q    <= '0;
      sh_dlc_q   <= '0;
      sh_data_q  <= '0;
      id_q       <= '0;
      dlc_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef CANRX_HOLD_EN
      ovr_q      <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef CANRX_HOLD_EN
      ovr_q <= frame_ok && !load;
      if (rx.rx_ack) valid_q <= 1'b0;
`else
      valid_q <= 1'b0;
`endif
      if (load) begin
        id_q    <= sh_id_q;
        dlc_q   <= sh_dlc_q;
        data_q  <= sh_data_q;
        valid_q <= 1'b1;
      end

      case (state_q)
        RX_IDLE: begin
          if (bit_in) begin
            if (idle_cnt_q != 4'hF) idle_cnt_q <= idle_cnt_q + 4'd1;
          end else begin
            idle_cnt_q <= '0;
            if (idle_cnt_q >= IDLE_TH) begin
              state_q   <= RX_ID;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              sh_id_q   <= '0;
              sh_dlc_q  <= '0;
              sh_data_q <= '0;
            end
          end
        end
        RX_ID: begin
          sh_id_q <= {sh_id_q[ID_W-2:0], bit_in};
          if (cnt_q == CNT_W'(ID_W - 1)) begin
            cnt_q   <= '0;
            state_q <= RX_RSV;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RX_RSV: begin
          if (bit_in) begin
            state_q <= RX_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(RSV_W - 1)) begin
            cnt_q   <= '0;
            state_q <= RX_DLC;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RX_DLC: begin
          sh_dlc_q <= dlc_d;
          if (cnt_q == CNT_W'(DLC_W - 1)) begin
            cnt_q <= '0;
            if (dlc_d > DLC_W'(MAX_BYTES)) begin
              state_q <= RX_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else if (dlc_d == '0) begin
              state_q <= RX_END;
            end else begin
              state_q <= RX_DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RX_DATA: begin
          // Bytes arrive in order, each MSB first.
          sh_data_q[cnt_q[5:3]][3'd7 - cnt_q[2:0]] <= bit_in;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == {sh_dlc_q, 3'b000} - CNT_ONE) state_q <= RX_END;
        end
        RX_END: begin
          if (bit_in) begin
            state_q    <= RX_IDLE;
            busy_q     <= 1'b0;
            idle_cnt_q <= 4'd1;
          end else begin
            state_q <= RX_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RX_ERR: begin
          state_q    <= RX_IDLE;
          idle_cnt_q <= '0;
          sh_id_q    <= '0;
          sh_dlc_q   <= '0;
          sh_data_q  <= '0;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx.rx_id     = id_q;
  assign rx.rx_dlc    = dlc_q;
  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_err    = err_q;
  assign rx.rx_busy   = busy_q;
  assign rx.dbg_state = state_q;

endmodule
